mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RV64 memory-access stage between execute and wb_stage. Accepts one instruction from EX over a
//  valid/ready handshake and runs loads/stores on a req/gnt/rvalid data bus. Aligns and sign/zero-
//  extends load data, then hands wb_stage a final writeback value: m_data, m_w_addr, m_reg_wr.
// PARAMETERS
//  XLEN    64  datapath width; equals `REG_BUS width
//  AW      64  data-bus address width
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-low reset
//  ex_valid       in   1       EX presents an instruction
//  ex_ready       out  1       stage can accept (state IDLE)
//  ex_alu_result  in   XLEN    ALU result / effective address
//  ex_store_data  in   XLEN    rs2 value for stores
//  ex_rd_addr     in   5       destination register
//  ex_reg_wr      in   1       instruction writes rd
//  ex_mem_rd      in   1       load
//  ex_mem_wr      in   1       store (never together with ex_mem_rd)
//  ex_funct3      in   3       size/sign: 000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  dmem_req       out  1       bus request, held until dmem_gnt
//  dmem_we        out  1       1 = store
//  dmem_addr      out  AW      doubleword-aligned address (addr[2:0] forced 0)
//  dmem_wdata     out  XLEN    store data shifted into byte lanes
//  dmem_wstrb     out  XLEN/8  byte enables
//  dmem_gnt       in   1       request accepted this cycle
//  dmem_rvalid    in   1       load data valid; never earlier than the cycle after gnt
//  dmem_rdata     in   XLEN    load data (full doubleword)
//  m_valid        out  1       1-cycle pulse per retired instruction
//  m_data         out  XLEN    final writeback value
//  m_w_addr       out  5       rd for wb_stage
//  m_reg_wr       out  1       writeback enable (0 when rd==0)
//  m_exc          out  1       misaligned access (MEM_MISALIGN_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; every output except ex_ready is 0; ex_ready=1 during reset.
//  - FSM: IDLE, REQ, WAIT, DONE. ex_ready=1 only in IDLE. Transfer = ex_valid & ex_ready at clk.
//  - IDLE + transfer, no mem op: latch fields, m_data=ex_alu_result; outputs valid next cycle
//    (1-cycle latency); stay IDLE.
//  - IDLE + transfer, load/store: latch fields, go REQ. REQ drives dmem_req=1 and stable
//    addr/we/wdata/wstrb until dmem_gnt. On gnt, store -> DONE; load -> WAIT.
//  - WAIT: dmem_rvalid ignored in REQ; on rvalid capture extended data, go DONE.
//  - DONE: m_valid=1 for one cycle with final outputs; back to IDLE (ex_ready=1 in the next cycle).
//    Store latency = gnt cycle+1; load = rvalid cycle+1.
//  - m_valid, m_reg_wr pulse for exactly one cycle; m_data/m_w_addr hold last value otherwise.
//  - Stores: m_reg_wr=0. Loads and ALU ops: m_reg_wr=ex_reg_wr & (rd!=0).
//  - Lane select off=addr[2:0]. Store wdata = rs2 << 8*off; wstrb = {1,3,F,FF}[size] << off.
//    Load: shift rdata right by 8*off, then sign-extend (B/H/W) or zero-extend (BU/HU/WU);
//    D is taken whole. Illegal funct3 (111) is treated as D.
//  - wb_stage must take m_* the same cycle; no backpressure from WB.
//  - Reset mid-transaction: request/response abandoned; dmem_req drops immediately.
//    A later rvalid is ignored.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined: at transfer, H off[0]!=0, W off[1:0]!=0, D off!=0 is misaligned.
//    No bus request; go straight to DONE with m_valid=1, m_exc=1, m_reg_wr=0, m_data=address.
//  Undefined: no check; m_exc tied 0; off used as-is and lanes beyond byte 7 dropped.
// TESTING
//  ALU op rd=5, result 0x1234 -> next cycle m_valid=1, m_data=0x1234, m_w_addr=5, m_reg_wr=1.
//  LB addr 0x1003, rdata 0x00000000_80000000 (byte3=0x80), gnt +2, rvalid +3
//    -> m_data=0xFFFFFFFFFFFFFF80 one cycle after rvalid; LBU same -> 0x80.
//  SH addr 0x2006, rs2=0xABCD -> dmem_wstrb=0xC0, dmem_wdata=0xABCD000000000000;
//    dmem_addr=0x2000; m_reg_wr=0.
//  gnt delayed 4 cycles -> dmem_req and addr stable 4 cycles, ex_ready=0 throughout.
//  ALU op with rd=0 -> m_valid=1, m_reg_wr=0.
//  rst low while in WAIT, rvalid arrives after release -> no m_valid; state IDLE.
//  MEM_MISALIGN_CHECK_EN defined, LW addr 0x1002 -> no dmem_req, m_exc=1, m_reg_wr=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-bus bundle between mem_stage (master) and the data memory (slave):
// req/gnt request handshake plus rvalid/rdata load response.
interface mem_stage_if #(
  parameter int XLEN = 64,
  parameter int AW   = 64
) ();
  logic              req;
  logic              we;
  logic [AW-1:0]     addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory-access stage: one instruction at a time from EX, loads/stores over a req/gnt/rvalid bus.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_reg_wr,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [2:0]      ex_funct3,
  mem_stage_if.master     dmem,
  output logic            m_valid,
  output logic [XLEN-1:0] m_data,
  output logic [4:0]      m_w_addr,
  output logic            m_reg_wr,
  output logic            m_exc
);

  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic            xfer;
  logic            is_mem;
  logic            misalign;
  logic            in_req;

  logic [AW-1:0]   addr_p0;
  logic [XLEN-1:0] wdata_p0;
  logic [SW-1:0]   strb_p0;
  logic [4:0]      rd_p0;
  logic            reg_wr_p0;
  logic            load_p0;
  logic [2:0]      funct3_p0;

  // Byte enables for the access size; funct3[1:0] alone picks the size (111 acts as D).
  function automatic logic [SW-1:0] lane_strb(input logic [2:0] f3, input logic [2:0] off);
    logic [SW-1:0] base;
    case (f3[1:0])
      2'b00:   base = SW'(8'h01);
      2'b01:   base = SW'(8'h03);
      2'b10:   base = SW'(8'h0F);
      default: base = SW'(8'hFF);
    endcase
    return base << off;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [XLEN-1:0] d, input logic [2:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [2:0]      f3,
                                                  input logic [2:0]      off);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{(XLEN-8){sh[7]}},   sh[7:0]};
      3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  res = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b100:  res = {{(XLEN-8){1'b0}},    sh[7:0]};
      3'b101:  res = {{(XLEN-16){1'b0}},   sh[15:0]};
      3'b110:  res = {{(XLEN-32){1'b0}},   sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = |off[1:0];
      2'b11:   bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  assign misalign = is_mem & is_misaligned(ex_funct3, ex_alu_result[2:0]);
`else
  assign misalign = 1'b0;
`endif

  assign ex_ready = (state == S_IDLE);
  assign xfer     = ex_valid & ex_ready;
  assign is_mem   = ex_mem_rd | ex_mem_wr;
  assign in_req   = (state == S_REQ);

  // Bus outputs are only live in REQ so reset and idle cycles present zeros.
  assign dmem.req   = in_req;
  assign dmem.we    = in_req & ~load_p0;
  assign dmem.addr  = in_req ? {addr_p0[AW-1:3], 3'b000} : '0;
  assign dmem.wdata = in_req ? wdata_p0 : '0;
  assign dmem.wstrb = in_req ? strb_p0 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (xfer && is_mem) state_nxt = misalign ? S_DONE : S_REQ;
      S_REQ:  if (dmem.gnt)       state_nxt = load_p0 ? S_WAIT : S_DONE;
      S_WAIT: if (dmem.rvalid)    state_nxt = S_DONE;
      S_DONE:                     state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // ---- p0: instruction fields captured at the EX transfer ----
  always_ff @(posedge clk) begin
    if (xfer) begin
      addr_p0   <= AW'(ex_alu_result);
      wdata_p0  <= store_lanes(ex_store_data, ex_alu_result[2:0]);
      strb_p0   <= lane_strb(ex_funct3, ex_alu_result[2:0]);
      rd_p0     <= ex_rd_addr;
      reg_wr_p0 <= ex_reg_wr;
      load_p0   <= ex_mem_rd;
      funct3_p0 <= ex_funct3;
    end
  end

  // ---- writeback outputs: m_valid/m_reg_wr pulse, data and rd hold between pulses ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_w_addr <= '0;
      m_reg_wr <= 1'b0;
    end else begin
      m_valid  <= 1'b0;
      m_reg_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && misalign) begin
            m_valid  <= 1'b1;
            m_data   <= ex_alu_result;
            m_w_addr <= ex_rd_addr;
          end else if (xfer && !is_mem) begin
            m_valid  <= 1'b1;
            m_data   <= ex_alu_result;
            m_w_addr <= ex_rd_addr;
            m_reg_wr <= ex_reg_wr & (ex_rd_addr != 5'd0);
          end
        end
        S_REQ: begin
          if (dmem.gnt && !load_p0) begin
            m_valid  <= 1'b1;
            m_w_addr <= rd_p0;
          end
        end
        S_WAIT: begin
          if (dmem.rvalid) begin
            m_valid  <= 1'b1;
            m_data   <= load_extend(dmem.rdata, funct3_p0, addr_p0[2:0]);
            m_w_addr <= rd_p0;
            m_reg_wr <= reg_wr_p0 & (rd_p0 != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) m_exc <= 1'b0;
    else      m_exc <= (state == S_IDLE) & xfer & misalign;
  end
`else
  assign m_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset corner cases and random ops
// checked against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_wr;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic        m_valid;
  logic [63:0] m_data;
  logic [4:0]  m_w_addr;
  logic        m_reg_wr;
  logic        m_exc;

  mem_stage_if #(.XLEN(64), .AW(64)) dmem ();

  mem_stage #(.XLEN(64), .AW(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_wr     (ex_reg_wr),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mem_wr     (ex_mem_wr),
    .ex_funct3     (ex_funct3),
    .dmem          (dmem),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_w_addr      (m_w_addr),
    .m_reg_wr      (m_reg_wr),
    .m_exc         (m_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;      // 0 ALU, 1 load, 2 store
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] d;
    logic [4:0]  rd;
    bit          wr;
    logic [63:0] rdata;
    int          gd;        // cycles before gnt
    int          rvd;       // cycles after gnt before rvalid
    logic [63:0] exp_data;
    bit          exp_wr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] prev_data = 64'h0;
  vec_t        vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int kind, input logic [2:0] f3,
                               input logic [63:0] a, input logic [63:0] d,
                               input logic [4:0] rd, input bit wr, input logic [63:0] rdata,
                               input int gd, input int rvd,
                               input logic [63:0] ed, input bit ew,
                               input logic [7:0] es, input logic [63:0] ewd);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.a = a; v.d = d; v.rd = rd; v.wr = wr; v.rdata = rdata;
    v.gd = gd; v.rvd = rvd; v.exp_data = ed; v.exp_wr = ew; v.exp_strb = es; v.exp_wdata = ewd;
    return v;
  endfunction

  // Reference model: access size in bytes and byte-by-byte lane placement.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [2:0] f3, input int off);
    logic [63:0] v;
    int n;
    bit sgn;
    v = 64'h0;
    n = size_of(f3);
    sgn = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (sgn && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] f3, input int off);
    logic [7:0] s;
    s = 8'h0;
    for (int i = 0; i < size_of(f3); i++)
      if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] d, input int off);
    logic [63:0] w;
    w = 64'h0;
    for (int j = 0; j < 8; j++)
      if (off + j < 8) w[8*(off+j) +: 8] = d[8*j +: 8];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input vec_t v);
    ex_valid      = 1'b1;
    ex_alu_result = v.a;
    ex_store_data = v.d;
    ex_rd_addr    = v.rd;
    ex_reg_wr     = v.wr;
    ex_mem_rd     = (v.kind == 1);
    ex_mem_wr     = (v.kind == 2);
    ex_funct3     = v.f3;
  endtask

  task automatic idle_ex();
    ex_valid      = 1'b0;
    ex_alu_result = {$urandom, $urandom};
    ex_store_data = {$urandom, $urandom};
    ex_rd_addr    = 5'($urandom);
    ex_mem_rd     = 1'b0;
    ex_mem_wr     = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string nm);
    logic [63:0] ea;
    ea = {v.a[63:3], 3'b000};
    chk({nm, "/ex_ready_before"}, 64'(ex_ready), 64'd1);
    drive_ex(v);
    tick();
    idle_ex();
    if (v.kind == 0) begin
      chk({nm, "/m_valid"},  64'(m_valid),  64'd1);
      chk({nm, "/m_data"},   m_data,        v.exp_data);
      chk({nm, "/m_w_addr"}, 64'(m_w_addr), 64'(v.rd));
      chk({nm, "/m_reg_wr"}, 64'(m_reg_wr), 64'(v.exp_wr));
      chk({nm, "/m_exc"},    64'(m_exc),    64'd0);
      prev_data = v.exp_data;
    end else begin
      chk({nm, "/req"},      64'(dmem.req), 64'd1);
      chk({nm, "/addr"},     dmem.addr,     ea);
      chk({nm, "/we"},       64'(dmem.we),  64'(v.kind == 2));
      chk({nm, "/ex_ready"}, 64'(ex_ready), 64'd0);
      if (v.kind == 2) begin
        chk({nm, "/wdata"}, dmem.wdata,      v.exp_wdata);
        chk({nm, "/wstrb"}, 64'(dmem.wstrb), 64'(v.exp_strb));
      end
      for (int i = 0; i < v.gd; i++) begin
        // rvalid noise while still requesting must be ignored
        dmem.rvalid = 1'($urandom);
        dmem.rdata  = {$urandom, $urandom};
        tick();
        chk({nm, "/req_hold"},      64'(dmem.req), 64'd1);
        chk({nm, "/addr_hold"},     dmem.addr,     ea);
        chk({nm, "/ready_hold"},    64'(ex_ready), 64'd0);
        chk({nm, "/valid_in_req"},  64'(m_valid),  64'd0);
      end
      dmem.rvalid = 1'b0;
      dmem.gnt    = 1'b1;
      tick();
      dmem.gnt    = 1'b0;
      if (v.kind == 2) begin
        chk({nm, "/st_m_valid"},  64'(m_valid),  64'd1);
        chk({nm, "/st_m_reg_wr"}, 64'(m_reg_wr), 64'd0);
        chk({nm, "/st_m_w_addr"}, 64'(m_w_addr), 64'(v.rd));
        chk({nm, "/st_m_data"},   m_data,        prev_data);
        chk({nm, "/st_m_exc"},    64'(m_exc),    64'd0);
      end else begin
        chk({nm, "/wait_req"},   64'(dmem.req), 64'd0);
        chk({nm, "/wait_valid"}, 64'(m_valid),  64'd0);
        for (int i = 0; i < v.rvd; i++) tick();
        dmem.rvalid = 1'b1;
        dmem.rdata  = v.rdata;
        tick();
        dmem.rvalid = 1'b0;
        dmem.rdata  = {$urandom, $urandom};
        chk({nm, "/ld_m_valid"},  64'(m_valid),  64'd1);
        chk({nm, "/ld_m_data"},   m_data,        v.exp_data);
        chk({nm, "/ld_m_w_addr"}, 64'(m_w_addr), 64'(v.rd));
        chk({nm, "/ld_m_reg_wr"}, 64'(m_reg_wr), 64'(v.exp_wr));
        chk({nm, "/ld_m_exc"},    64'(m_exc),    64'd0);
        prev_data = v.exp_data;
      end
    end
    tick();
    chk({nm, "/pulse_end"},   64'(m_valid),  64'd0);
    chk({nm, "/reg_wr_end"},  64'(m_reg_wr), 64'd0);
    chk({nm, "/ready_after"}, 64'(ex_ready), 64'd1);
    chk({nm, "/data_hold"},   m_data,        prev_data);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "/m_valid"},  64'(m_valid),    64'd0);
    chk({nm, "/m_data"},   m_data,          64'd0);
    chk({nm, "/m_w_addr"}, 64'(m_w_addr),   64'd0);
    chk({nm, "/m_reg_wr"}, 64'(m_reg_wr),   64'd0);
    chk({nm, "/m_exc"},    64'(m_exc),      64'd0);
    chk({nm, "/req"},      64'(dmem.req),   64'd0);
    chk({nm, "/we"},       64'(dmem.we),    64'd0);
    chk({nm, "/addr"},     dmem.addr,       64'd0);
    chk({nm, "/wdata"},    dmem.wdata,      64'd0);
    chk({nm, "/wstrb"},    64'(dmem.wstrb), 64'd0);
    chk({nm, "/ex_ready"}, 64'(ex_ready),   64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    rst = 1'b0;
    ex_reg_wr = 1'b0;
    ex_funct3 = 3'd0;
    idle_ex();
    dmem.gnt = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata = 64'h0;

    vt.push_back(mkv(0, 3'd0, 64'h1234, 0, 5'd5, 1, 0, 0, 0, 64'h1234, 1, 0, 0));
    vt.push_back(mkv(0, 3'd0, 64'h55, 0, 5'd0, 1, 0, 0, 0, 64'h55, 0, 0, 0));
    vt.push_back(mkv(1, 3'd0, 64'h1003, 0, 5'd7, 1, 64'h0000_0000_8000_0000, 2, 0,
                     64'hFFFF_FFFF_FFFF_FF80, 1, 0, 0));
    vt.push_back(mkv(1, 3'd4, 64'h1003, 0, 5'd7, 1, 64'h0000_0000_8000_0000, 2, 0,
                     64'h80, 1, 0, 0));
    vt.push_back(mkv(2, 3'd1, 64'h2006, 64'hABCD, 5'd9, 1, 0, 4, 0, 0, 0,
                     8'hC0, 64'hABCD_0000_0000_0000));
    vt.push_back(mkv(1, 3'd2, 64'h1004, 0, 5'd10, 1, 64'h89AB_CDEF_0123_4567, 0, 1,
                     64'hFFFF_FFFF_89AB_CDEF, 1, 0, 0));
    vt.push_back(mkv(1, 3'd6, 64'h1004, 0, 5'd10, 1, 64'h89AB_CDEF_0123_4567, 1, 2,
                     64'h0000_0000_89AB_CDEF, 1, 0, 0));
    vt.push_back(mkv(1, 3'd1, 64'h1002, 0, 5'd11, 1, 64'h0000_0000_7FFF_0000, 0, 0,
                     64'h7FFF, 1, 0, 0));
    vt.push_back(mkv(1, 3'd5, 64'h1006, 0, 5'd12, 1, 64'hFEDC_0000_0000_0000, 1, 0,
                     64'hFEDC, 1, 0, 0));
    vt.push_back(mkv(1, 3'd3, 64'h1000, 0, 5'd13, 1, 64'h0123_4567_89AB_CDEF, 0, 0,
                     64'h0123_4567_89AB_CDEF, 1, 0, 0));
    vt.push_back(mkv(2, 3'd3, 64'h3000, 64'h1122_3344_5566_7788, 5'd1, 0, 0, 1, 0, 0, 0,
                     8'hFF, 64'h1122_3344_5566_7788));
    vt.push_back(mkv(2, 3'd0, 64'h3005, 64'hFFFF_FFFF_FFFF_FF5A, 5'd2, 1, 0, 0, 0, 0, 0,
                     8'h20, 64'hFFFF_5A00_0000_0000));
    vt.push_back(mkv(2, 3'd2, 64'h3004, 64'hDEAD_BEEF, 5'd3, 1, 0, 2, 0, 0, 0,
                     8'hF0, 64'hDEAD_BEEF_0000_0000));
    vt.push_back(mkv(1, 3'd3, 64'h1008, 0, 5'd0, 1, 64'h5555_AAAA_5555_AAAA, 0, 0,
                     64'h5555_AAAA_5555_AAAA, 0, 0, 0));
    vt.push_back(mkv(1, 3'd7, 64'h1010, 0, 5'd14, 1, 64'hCAFE_F00D_DEAD_BEEF, 0, 0,
                     64'hCAFE_F00D_DEAD_BEEF, 1, 0, 0));
    vt.push_back(mkv(1, 3'd0, 64'h1001, 0, 5'd3, 0, 64'h0000_0000_0000_FF00, 0, 0,
                     64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0));
`ifndef MEM_MISALIGN_CHECK_EN
    vt.push_back(mkv(1, 3'd2, 64'h1006, 0, 5'd15, 1, 64'hAABB_CCDD_0000_0000, 0, 0,
                     64'h0000_0000_0000_AABB, 1, 0, 0));
    vt.push_back(mkv(2, 3'd2, 64'h3006, 64'h1122_3344, 5'd4, 1, 0, 0, 0, 0, 0,
                     8'hC0, 64'h3344_0000_0000_0000));
`endif

    // Reset state, with the clock running
    repeat (3) tick();
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_reset_outputs("post_reset");

    foreach (vt[i]) run_op(vt[i], $sformatf("vec%0d", i));

    // Reset while waiting for load data; the late rvalid must be dropped
    v = mkv(1, 3'd3, 64'h4000, 0, 5'd6, 1, 0, 0, 0, 0, 0, 0, 0);
    drive_ex(v);
    tick();
    idle_ex();
    dmem.gnt = 1'b1;
    tick();
    dmem.gnt = 1'b0;
    chk("rst_wait/in_wait_req", 64'(dmem.req), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_wait/ready", 64'(ex_ready), 64'd1);
    chk("rst_wait/m_data", m_data, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    prev_data = 64'h0;
    tick();
    dmem.rvalid = 1'b1;
    dmem.rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    dmem.rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait/no_valid", 64'(m_valid), 64'd0);
      chk("rst_wait/idle",     64'(ex_ready), 64'd1);
      tick();
    end

    // Reset while requesting: dmem_req must drop without waiting for a clock
    v = mkv(2, 3'd3, 64'h5000, 64'h77, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0);
    drive_ex(v);
    tick();
    idle_ex();
    chk("rst_req/req_before", 64'(dmem.req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_req/req_dropped", 64'(dmem.req), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dmem.gnt = 1'b1;
    tick();
    dmem.gnt = 1'b0;
    tick();
    chk("rst_req/no_valid", 64'(m_valid), 64'd0);
    chk("rst_req/idle",     64'(ex_ready), 64'd1);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned LW traps without touching the bus
    v = mkv(1, 3'd2, 64'h1002, 0, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0);
    drive_ex(v);
    tick();
    idle_ex();
    chk("mis/req",      64'(dmem.req), 64'd0);
    chk("mis/m_valid",  64'(m_valid),  64'd1);
    chk("mis/m_exc",    64'(m_exc),    64'd1);
    chk("mis/m_reg_wr", 64'(m_reg_wr), 64'd0);
    chk("mis/m_data",   m_data,        64'h1002);
    prev_data = 64'h1002;
    tick();
    chk("mis/pulse_end", 64'(m_valid), 64'd0);
    chk("mis/exc_end",   64'(m_exc),   64'd0);
    chk("mis/ready",     64'(ex_ready), 64'd1);
`endif

    // Random operations against the reference model
    for (int k = 0; k < 60; k++) begin
      int off;
      int n;
      v.kind  = int'($urandom_range(0, 2));
      v.f3    = 3'($urandom_range(0, 7));
      off     = int'($urandom_range(0, 7));
      n       = size_of(v.f3);
`ifdef MEM_MISALIGN_CHECK_EN
      if (v.kind != 0) off = off - (off % n);
`endif
      v.a       = {$urandom, $urandom};
      v.a[2:0]  = 3'(off);
      v.d       = {$urandom, $urandom};
      v.rd      = 5'($urandom_range(0, 31));
      v.wr      = 1'($urandom);
      v.rdata   = {$urandom, $urandom};
      v.gd      = int'($urandom_range(0, 3));
      v.rvd     = int'($urandom_range(0, 3));
      v.exp_strb  = ref_strb(v.f3, off);
      v.exp_wdata = ref_wdata(v.d, off);
      v.exp_wr    = v.wr && (v.rd != 5'd0) && (v.kind != 2);
      if (v.kind == 0)      v.exp_data = v.a;
      else if (v.kind == 1) v.exp_data = ref_load(v.rdata, v.f3, off);
      else                  v.exp_data = 64'h0;
      run_op(v, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
